// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx with first-word-fall-through output,
// sticky overflow flag and RTS flow control with hysteresis.
module uart_byte_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned RTS_OFF = 12,
  parameter int unsigned RTS_ON  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_req,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_req,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [AW:0]   level,
  output logic          rts,
  output logic          overflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] OFF_LVL  = (AW+1)'(RTS_OFF);
  localparam logic [AW:0] ON_LVL   = (AW+1)'(RTS_ON);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_next;
  logic          push;
  logic          pop;

  // Handshake flags come from the registered level only, so neither ready
  // nor req depends combinationally on the opposite side's inputs.
  assign in_ready = (level_q != FULL_LVL);
  assign out_req  = (level_q != '0);
  assign push     = in_req & in_ready;
  assign pop      = out_req & out_ready;
  assign out_data = mem[rd_ptr];
  assign level    = level_q;

  always_comb begin
    level_next = level_q;
    if (push && !pop)
      level_next = level_q + 1'b1;
    else if (pop && !push)
      level_next = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      rts      <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_next;
      // Hysteresis on the post-update level; between the thresholds rts holds.
      if (level_next >= OFF_LVL)
        rts <= 1'b0;
      else if (level_next <= ON_LVL)
        rts <= 1'b1;
      if (in_req && !in_ready)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: directed scenarios plus a randomized
// phase, all compared against a queue-based occupancy model.
module tb_uart_byte_fifo;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned RTS_OFF = 12;
  localparam int unsigned RTS_ON  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_req = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_req;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [AW:0] level;
  logic        rts;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] got[$];
  logic       m_rts = 1'b1;
  logic       m_ovf = 1'b0;

  uart_byte_fifo #(
    .DEPTH(DEPTH),
    .AW(AW),
    .RTS_OFF(RTS_OFF),
    .RTS_ON(RTS_ON)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_req(in_req),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_req(out_req),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level),
    .rts(rts),
    .overflow(overflow)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    check("out_req", 32'(out_req), 32'(q.size() != 0));
    check("rts", 32'(rts), 32'(m_rts));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0)
      check("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // One clock cycle: drive, check the pre-edge state, advance the model.
  task automatic step(input logic req, input logic [7:0] data, input logic ordy);
    bit do_push, do_pop;
    in_req    = req;
    in_data   = data;
    out_ready = ordy;
    @(negedge clk);
    check_state();
    do_push = req && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    if (req && q.size() == DEPTH)
      m_ovf = 1'b1;
    if (do_pop) begin
      got.push_back(out_data);
      void'(q.pop_front());
    end
    if (do_push)
      q.push_back(data);
    if (q.size() >= RTS_OFF)
      m_rts = 1'b0;
    else if (q.size() <= RTS_ON)
      m_rts = 1'b1;
    @(posedge clk);
    #1;
    in_req    = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_req    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    got.delete();
    m_rts = 1'b1;
    m_ovf = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_req", 32'(out_req), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rts", 32'(rts), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single byte: visible next cycle, gone after one pop.
    step(1'b1, 8'h41, 1'b0);
    check("single_req", 32'(out_req), 32'd1);
    check("single_data", 32'(out_data), 32'h41);
    check("single_level", 32'(level), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("single_drained", 32'(level), 32'd0);
    check("single_req_low", 32'(out_req), 32'd0);

    // Order and wrap: 40 bytes through with continuous popping.
    got.delete();
    for (int i = 0; i < 40; i++)
      step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("wrap_count", 32'(got.size()), 32'd40);
    for (int i = 0; i < 40 && i < got.size(); i++)
      check("wrap_order", 32'(got[i]), 32'(i));
    check("wrap_overflow", 32'(overflow), 32'd0);

    // Full, overflow, push+pop at full and at level 8.
    do_reset();
    for (int i = 0; i < 16; i++)
      step(1'b1, 8'(8'h80 + i), 1'b0);
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 8'hFF, 1'b0);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_level_hold", 32'(level), 32'd16);
    step(1'b1, 8'hAA, 1'b1);
    check("full_pushpop_level", 32'(level), 32'd15);
    for (int i = 0; i < 7; i++)
      step(1'b0, 8'h00, 1'b1);
    check("mid_level", 32'(level), 32'd8);
    step(1'b1, 8'hBB, 1'b1);
    check("mid_pushpop_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++)
      step(1'b0, 8'h00, 1'b1);
    check("full_drain_count", 32'(got.size()), 32'd17);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check("full_drain_order", 32'(got[i]), 32'(8'h80 + i));
    if (got.size() == 17)
      check("full_drain_last", 32'(got[16]), 32'hBB);

    // RTS hysteresis: fill to 12, drain to 4.
    do_reset();
    for (int i = 0; i < 11; i++)
      step(1'b1, 8'(i), 1'b0);
    check("rts_at11_up", 32'(rts), 32'd1);
    step(1'b1, 8'h0B, 1'b0);
    check("rts_at12_down", 32'(rts), 32'd0);
    for (int i = 0; i < 7; i++)
      step(1'b0, 8'h00, 1'b1);
    check("rts_at5_down", 32'(rts), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("rts_at4_up", 32'(rts), 32'd1);

    // Reset mid-stream with 10 bytes queued.
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, 8'(8'h30 + i), 1'b0);
    check("pre_rst_rts", 32'(rts), 32'd1);
    do_reset();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_out_req", 32'(out_req), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_rts", 32'(rts), 32'd1);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    step(1'b1, 8'h55, 1'b0);
    check("mid_rst_first", 32'(out_data), 32'h55);
    step(1'b0, 8'h00, 1'b1);

    // Randomized traffic with alternating fill-biased and drain-biased phases.
    do_reset();
    for (int c = 0; c < 2400; c++) begin
      int unsigned p_in, p_out;
      p_in  = ((c / 150) % 2 == 0) ? 80 : 35;
      p_out = ((c / 150) % 2 == 0) ? 30 : 75;
      step(($urandom_range(99) < p_in), 8'($urandom), ($urandom_range(99) < p_out));
    end
    step(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
